// File: rtl/bounce_generator_if.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | bounce_generator_if : request handshake and noisy-line status bundle
// | Rev 1.0
// +----------------------------------------------------------------------------
interface bounce_generator_if;
  logic       req_valid;
  logic       req_level;
  logic [7:0] req_len;
  logic       req_ready;
  logic       noisy_out;
  logic       busy;
  logic       settled;
  logic [7:0] glitch_count;

  modport master (
    output req_valid, req_level, req_len,
    input  req_ready, noisy_out, busy, settled, glitch_count
  );

  modport slave (
    input  req_valid, req_level, req_len,
    output req_ready, noisy_out, busy, settled, glitch_count
  );
endinterface
`default_nettype wire

// File: rtl/bounce_generator.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | bounce_generator : LFSR-driven contact-bounce burst followed by a settled hold
// | Rev 1.0
// +----------------------------------------------------------------------------
module bounce_generator #(
  parameter int unsigned N          = 3,
  parameter int unsigned BOUNCE_MAX = 8,
  parameter logic [7:0]  SEED       = 8'hA5
) (
  input  wire logic         clk,
  input  wire logic         rst,
  bounce_generator_if.slave bus
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_BOUNCE = 2'd1;
  localparam logic [1:0] c_SETTLE = 2'd2;
  localparam logic [1:0] c_DONE   = 2'd3;

  localparam logic [7:0] c_SEED       = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [3:0] c_RUN_MAX    = 4'(N - 1);
  localparam logic [7:0] c_BMAX       = 8'(BOUNCE_MAX);
  localparam logic [7:0] c_SETTLE_LEN = 8'(N);

  logic [1:0] r_state;
  logic [7:0] r_lfsr;
  logic [7:0] r_cnt;
  logic [7:0] r_glitch;
  logic [3:0] r_run;
  logic       r_noisy;
  logic       r_target;
  logic       r_settled;

  logic [1:0] w_state_nxt;
  logic [7:0] w_cnt_nxt;
  logic [7:0] w_len;
  logic       w_noisy_nxt;
  logic       w_target_nxt;
  logic       w_settled_nxt;
  logic       w_hs;
  logic       w_fb;
  logic       w_bounce;

  assign bus.req_ready    = (r_state == c_IDLE) && !rst;
  assign bus.busy         = (r_state != c_IDLE);
  assign bus.noisy_out    = r_noisy;
  assign bus.settled      = r_settled;
  assign bus.glitch_count = r_glitch;

  assign w_hs  = bus.req_valid && bus.req_ready;
  assign w_len = (bus.req_len > c_BMAX) ? c_BMAX : bus.req_len;
  assign w_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  // A run about to reach N cycles is broken so the downstream debouncer never locks mid-burst.
  assign w_bounce = (r_run >= c_RUN_MAX) ? ~r_noisy : r_lfsr[0];

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_noisy_nxt   = r_noisy;
    w_target_nxt  = r_target;
    w_settled_nxt = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (w_hs) begin
          w_target_nxt = bus.req_level;
          if (w_len != 8'd0) begin
            w_state_nxt = c_BOUNCE;
            w_cnt_nxt   = w_len - 8'd1;
            w_noisy_nxt = w_bounce;
          end else begin
            w_state_nxt = c_SETTLE;
            w_cnt_nxt   = c_SETTLE_LEN;
            w_noisy_nxt = bus.req_level;
          end
        end
      end
      c_BOUNCE: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = c_SETTLE;
          w_cnt_nxt   = c_SETTLE_LEN;
          w_noisy_nxt = r_target;
        end else begin
          w_cnt_nxt   = r_cnt - 8'd1;
          w_noisy_nxt = w_bounce;
        end
      end
      c_SETTLE: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt   = c_DONE;
          w_settled_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      default: begin
        w_state_nxt = c_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_IDLE;
      r_lfsr    <= c_SEED;
      r_cnt     <= 8'd0;
      r_glitch  <= 8'd0;
      r_run     <= c_RUN_MAX;
      r_noisy   <= 1'b0;
      r_target  <= 1'b0;
      r_settled <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_lfsr    <= {r_lfsr[6:0], w_fb};
      r_cnt     <= w_cnt_nxt;
      r_noisy   <= w_noisy_nxt;
      r_target  <= w_target_nxt;
      r_settled <= w_settled_nxt;
      if (w_noisy_nxt != r_noisy) begin
        r_run <= 4'd1;
        if (r_glitch != 8'hFF) begin
          r_glitch <= r_glitch + 8'd1;
        end
      end else if (r_run < c_RUN_MAX) begin
        r_run <= r_run + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bounce_generator.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_bounce_generator : directed self-checking bench for bounce_generator
// | Rev 1.0
// +----------------------------------------------------------------------------
module tb_bounce_generator;

  localparam int         N    = 3;
  localparam int         BMAX = 8;
  localparam logic [7:0] SEED = 8'hA5;

  logic clk = 1'b0;
  logic rst;

  bounce_generator_if bus ();

  bounce_generator #(
    .N          (N),
    .BOUNCE_MAX (BMAX),
    .SEED       (SEED)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference LFSR: m_bit is the lfsr[0] the DUT used at the most recent edge.
  logic [7:0] m_lfsr;
  logic       m_bit;
  always @(posedge clk) begin
    m_bit <= m_lfsr[0];
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  // Reference N-cycle debouncer watching the noisy line.
  logic       db_prev, db_out;
  logic [3:0] db_cnt;
  always @(posedge clk) begin
    if (rst) begin
      db_prev <= 1'b0;
      db_cnt  <= 4'd0;
      db_out  <= 1'b0;
    end else begin
      db_prev <= bus.noisy_out;
      if (bus.noisy_out == db_prev) begin
        if (db_cnt < 4'(N)) db_cnt <= db_cnt + 4'd1;
        if (32'(db_cnt) + 1 >= N) db_out <= bus.noisy_out;
      end else begin
        db_cnt <= 4'd1;
      end
    end
  end

  logic e_noisy;
  int   e_run;
  int   e_glitch;

  task automatic model_reset();
    e_noisy  = 1'b0;
    e_run    = N - 1;
    e_glitch = 0;
  endtask

  function automatic logic bounce_bit();
    return (e_run >= N - 1) ? ~e_noisy : m_bit;
  endfunction

  task automatic model_step(input logic b);
    if (b !== e_noisy) begin
      if (e_glitch < 255) e_glitch++;
      e_run = 1;
    end else if (e_run < N - 1) begin
      e_run++;
    end
    e_noisy = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      model_step(e_noisy);
    end
  endtask

  // Leaves the bench at the negedge following the handshake edge.
  task automatic issue(input logic level, input logic [7:0] len);
    bus.req_valid = 1'b1;
    bus.req_level = level;
    bus.req_len   = len;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_level = 1'b0;
    bus.req_len   = 8'd0;
    model_reset();
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      checks++; if (bus.noisy_out !== 1'b0) begin errors++; $display("FAIL reset_noisy: got %b expected 0", bus.noisy_out); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.settled !== 1'b0) begin errors++; $display("FAIL reset_settled: got %b expected 0", bus.settled); end
      checks++; if (bus.glitch_count !== 8'd0) begin errors++; $display("FAIL reset_glitch: got %0d expected 0", bus.glitch_count); end
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.req_ready); end
    end
    rst = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", bus.req_ready); end
  endtask

  // Issued directly after reset release; the second request returns the line to 0.
  task automatic test_zero_len();
    for (int r = 0; r < 2; r++) begin
      logic lv;
      lv = (r == 0);
      issue(lv, 8'd0);
      for (int j = 0; j < N + 2; j++) begin
        if (j > 0) begin @(posedge clk); @(negedge clk); end
        model_step(lv);
        checks++; if (bus.noisy_out !== lv) begin errors++; $display("FAIL zero_noisy j=%0d: got %b expected %b", j, bus.noisy_out, lv); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL zero_busy j=%0d: got %b expected 1", j, bus.busy); end
        checks++; if (bus.settled !== (j == N + 1)) begin errors++; $display("FAIL zero_settled j=%0d: got %b expected %b", j, bus.settled, (j == N + 1)); end
      end
      idle(1);
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL zero_ready_back: got %b expected 1", bus.req_ready); end
      checks++; if (bus.settled !== 1'b0) begin errors++; $display("FAIL zero_settled_drop: got %b expected 0", bus.settled); end
      checks++; if (bus.glitch_count !== 8'(r + 1)) begin errors++; $display("FAIL zero_glitch: got %0d expected %0d", bus.glitch_count, r + 1); end
      idle(2);
    end
  endtask

  task automatic test_burst();
    localparam int L = 5;
    int   rises, runlen, maxrun;
    logic prev, prev_db;
    rises = 0; runlen = 0; maxrun = 0;
    prev = bus.noisy_out; prev_db = db_out;
    issue(1'b1, 8'(L));
    for (int j = 0; j < L + N + 2; j++) begin
      if (j > 0) begin @(posedge clk); @(negedge clk); end
      if (j < L) model_step(bounce_bit());
      else       model_step(1'b1);
      checks++; if (bus.noisy_out !== e_noisy) begin errors++; $display("FAIL burst_noisy j=%0d: got %b expected %b", j, bus.noisy_out, e_noisy); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL burst_busy j=%0d: got %b expected 1", j, bus.busy); end
      checks++; if (bus.settled !== (j == L + N + 1)) begin errors++; $display("FAIL burst_settled j=%0d: got %b expected %b", j, bus.settled, (j == L + N + 1)); end
      checks++; if (bus.glitch_count !== 8'(e_glitch)) begin errors++; $display("FAIL burst_glitch j=%0d: got %0d expected %0d", j, bus.glitch_count, e_glitch); end
      if (j == 0) begin
        checks++; if (bus.noisy_out !== 1'b1) begin errors++; $display("FAIL burst_first_toggle: got %b expected 1", bus.noisy_out); end
      end
      if (j < L) begin
        runlen = (j > 0 && bus.noisy_out == prev) ? runlen + 1 : 1;
        if (runlen > maxrun) maxrun = runlen;
      end
      if (db_out && !prev_db) rises++;
      prev = bus.noisy_out;
      prev_db = db_out;
    end
    idle(1);
    if (db_out && !prev_db) rises++;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL burst_ready_back: got %b expected 1", bus.req_ready); end
    checks++; if (maxrun >= N) begin errors++; $display("FAIL burst_max_run: got %0d expected below %0d", maxrun, N); end
    checks++; if (rises != 1) begin errors++; $display("FAIL burst_debounce_rises: got %0d expected 1", rises); end
    idle(2);
  endtask

  task automatic test_clamp();
    localparam int L = BMAX;
    int busy_cycles;
    busy_cycles = 0;
    issue(1'b0, 8'd20);
    for (int j = 0; j < L + N + 2; j++) begin
      if (j > 0) begin @(posedge clk); @(negedge clk); end
      bus.req_valid = (j == 3);
      bus.req_level = 1'b1;
      bus.req_len   = 8'd5;
      if (j < L) model_step(bounce_bit());
      else       model_step(1'b0);
      if (bus.busy === 1'b1) busy_cycles++;
      checks++; if (bus.noisy_out !== e_noisy) begin errors++; $display("FAIL clamp_noisy j=%0d: got %b expected %b", j, bus.noisy_out, e_noisy); end
      checks++; if (bus.settled !== (j == L + N + 1)) begin errors++; $display("FAIL clamp_settled j=%0d: got %b expected %b", j, bus.settled, (j == L + N + 1)); end
    end
    bus.req_valid = 1'b0;
    checks++; if (busy_cycles != 13) begin errors++; $display("FAIL clamp_busy_cycles: got %0d expected 13", busy_cycles); end
    for (int j = 0; j < 4; j++) begin
      idle(1);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL clamp_no_second j=%0d: got busy %b expected 0", j, bus.busy); end
      checks++; if (bus.noisy_out !== 1'b0) begin errors++; $display("FAIL clamp_hold j=%0d: got %b expected 0", j, bus.noisy_out); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] pat;
    pat = 8'h65;  // first eight burst bits of a level-1 request issued right after reset release
    issue(1'b1, 8'd8);
    for (int j = 0; j < 3; j++) begin
      if (j > 0) begin @(posedge clk); @(negedge clk); end
      model_step(bounce_bit());
      checks++; if (bus.noisy_out !== e_noisy) begin errors++; $display("FAIL mid_pre_noisy j=%0d: got %b expected %b", j, bus.noisy_out, e_noisy); end
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.noisy_out !== 1'b0) begin errors++; $display("FAIL mid_rst_noisy: got %b expected 0", bus.noisy_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.glitch_count !== 8'd0) begin errors++; $display("FAIL mid_rst_glitch: got %0d expected 0", bus.glitch_count); end
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b expected 0", bus.req_ready); end
    rst = 1'b0;
    model_reset();
    issue(1'b1, 8'd8);
    for (int j = 0; j < 8 + N + 2; j++) begin
      if (j > 0) begin @(posedge clk); @(negedge clk); end
      if (j < 8) model_step(bounce_bit());
      else       model_step(1'b1);
      if (j < 8) begin
        checks++; if (bus.noisy_out !== pat[j]) begin errors++; $display("FAIL replay_bit j=%0d: got %b expected %b", j, bus.noisy_out, pat[j]); end
      end
      checks++; if (bus.noisy_out !== e_noisy) begin errors++; $display("FAIL replay_noisy j=%0d: got %b expected %b", j, bus.noisy_out, e_noisy); end
      checks++; if (bus.glitch_count !== 8'(e_glitch)) begin errors++; $display("FAIL replay_glitch j=%0d: got %0d expected %0d", j, bus.glitch_count, e_glitch); end
    end
    idle(2);
  endtask

  task automatic test_saturation();
    int last, r;
    last = int'(bus.glitch_count);
    r = 0;
    while ((r < 40 || e_glitch < 255) && r < 120) begin
      issue(r[0] == 1'b0, 8'd8);
      for (int j = 0; j < 8 + N + 2; j++) begin
        if (j > 0) begin @(posedge clk); @(negedge clk); end
        if (j < 8) model_step(bounce_bit());
        else       model_step(r[0] == 1'b0);
        checks++; if (bus.noisy_out !== e_noisy) begin errors++; $display("FAIL sat_noisy r=%0d j=%0d: got %b expected %b", r, j, bus.noisy_out, e_noisy); end
      end
      idle(1);
      checks++; if (bus.glitch_count !== 8'(e_glitch)) begin errors++; $display("FAIL sat_glitch r=%0d: got %0d expected %0d", r, bus.glitch_count, e_glitch); end
      checks++; if (int'(bus.glitch_count) < last) begin errors++; $display("FAIL sat_no_wrap r=%0d: got %0d expected at least %0d", r, bus.glitch_count, last); end
      last = int'(bus.glitch_count);
      r++;
    end
    checks++; if (bus.glitch_count !== 8'd255) begin errors++; $display("FAIL sat_final: got %0d expected 255", bus.glitch_count); end
  endtask

  initial begin
    test_reset();
    test_zero_len();
    test_burst();
    test_clamp();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
